mod_mul: RTL and testbench

- Bit-serial interleaved modular multiplier: result = (a * b) mod `prime, with `prime taken from state_define.vh.
- Sits directly downstream of the modular inverter in the ECDSA datapath. It consumes the inverse (e.g. lambda = (y2-y1)*inv(x2-x1) in point add, s = k^-1*(z+r*d) in signing).
- Processes one multiplier bit per clock, MSB first, with a start/busy/done handshake.

---
 rtl/mod_mul_if.sv | 16 +
 rtl/mod_mul.sv | 141 ++++++++++++++
 tb/tb_mod_mul.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_mul_if.sv
// Start/busy/done handshake and operand/result bus of the modular multiplier.
interface mod_mul_if #(
   parameter int unsigned WIDTH = 256
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (output start, output a, output b,
                   input  busy,  input  done, input result);
   modport slave  (input  start, input  a, input  b,
                   output busy,  output done, output result);
endinterface

// File: rtl/mod_mul.sv
// Bit-serial interleaved modular multiplier: result = (a * b) mod the prime.
// One multiplier bit per clock, MSB first; start/busy/done handshake.
// The prime normally comes from state_define.vh; a secp256k1 default is
// provided when the macro is not already defined.
// Optional: MODMUL_INPUT_REDUCE_EN adds a LOAD state that reduces any
// WIDTH-bit operand below the prime before the multiply loop.
`ifndef MODMUL_PRIME
`define MODMUL_PRIME 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
`endif

module mod_mul #(
   parameter int unsigned WIDTH = 256
) (
   input  logic     clk,
   input  logic     rst_n,
   mod_mul_if.slave bus
);
   localparam int unsigned WP1   = WIDTH + 1;
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH:0] PRIME = WP1'(`MODMUL_PRIME);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2,
      S_LOAD = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   a_r, a_nxt;
   logic [WIDTH-1:0]   b_r, b_nxt;
   logic [WIDTH-1:0]   p_r, p_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               busy_r, busy_nxt;
   logic               done_r, done_nxt;
   logic [WIDTH-1:0]   result_r, result_nxt;

   // Datapath: widened WIDTH+1-bit values so the carry is kept for the compares.
   logic [WIDTH:0]     t_dbl, t_red, u_sum, u_red;
   logic [WIDTH-1:0]   p_step;
`ifdef MODMUL_INPUT_REDUCE_EN
   logic [WIDTH-1:0]   a_load, b_load;
`endif

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;

   // One interleaved step: P' = (2P + B[i]*A) mod prime, with single-subtract reductions.
   always_comb begin
      t_dbl  = {p_r, 1'b0};
      t_red  = (t_dbl >= PRIME) ? (t_dbl - PRIME) : t_dbl;
      u_sum  = t_red + {1'b0, a_r};
      u_red  = (u_sum >= PRIME) ? (u_sum - PRIME) : u_sum;
      p_step = b_r[cnt] ? u_red[WIDTH-1:0] : t_red[WIDTH-1:0];
   end

`ifdef MODMUL_INPUT_REDUCE_EN
   // Operand pre-reduction; one subtract suffices since prime > 2^(WIDTH-1).
   always_comb begin
      a_load = ({1'b0, a_r} >= PRIME) ? WIDTH'({1'b0, a_r} - PRIME) : a_r;
      b_load = ({1'b0, b_r} >= PRIME) ? WIDTH'({1'b0, b_r} - PRIME) : b_r;
   end
`endif

   // Next-state and next-register values for the control FSM.
   always_comb begin
      state_nxt  = state;
      a_nxt      = a_r;
      b_nxt      = b_r;
      p_nxt      = p_r;
      cnt_nxt    = cnt;
      busy_nxt   = busy_r;
      done_nxt   = 1'b0;
      result_nxt = result_r;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               a_nxt    = bus.a;
               b_nxt    = bus.b;
               p_nxt    = '0;
               cnt_nxt  = CNT_W'(WIDTH - 1);
               busy_nxt = 1'b1;
`ifdef MODMUL_INPUT_REDUCE_EN
               state_nxt = S_LOAD;
`else
               state_nxt = S_RUN;
`endif
            end
         end
`ifdef MODMUL_INPUT_REDUCE_EN
         S_LOAD: begin
            a_nxt     = a_load;
            b_nxt     = b_load;
            state_nxt = S_RUN;
         end
`endif
         S_RUN: begin
            p_nxt = p_step;
            if (cnt == '0) begin
               state_nxt = S_FIN;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_FIN: begin
            result_nxt = p_r;
            done_nxt   = 1'b1;
            busy_nxt   = 1'b0;
            state_nxt  = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; synchronous reset aborts any operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         a_r      <= '0;
         b_r      <= '0;
         p_r      <= '0;
         cnt      <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
      end else begin
         state    <= state_nxt;
         a_r      <= a_nxt;
         b_r      <= b_nxt;
         p_r      <= p_nxt;
         cnt      <= cnt_nxt;
         busy_r   <= busy_nxt;
         done_r   <= done_nxt;
         result_r <= result_nxt;
      end
   end
endmodule

// File: tb/tb_mod_mul.sv
// Self-checking bench for mod_mul: latency-level reference model plus
// directed and random operations. Honours MODMUL_INPUT_REDUCE_EN.
`ifndef MODMUL_PRIME
`define MODMUL_PRIME 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
`endif

module tb_mod_mul;
   localparam int unsigned W = 256;
   localparam logic [W-1:0] PRIME = W'(`MODMUL_PRIME);
`ifdef MODMUL_INPUT_REDUCE_EN
   localparam int LAT = W + 2;
`else
   localparam int LAT = W + 1;
`endif
   localparam int N_RAND = 110;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mod_mul_if #(.WIDTH(W)) bus ();

   mod_mul #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] pr;
      pr = (2*W)'(x) * (2*W)'(y);
      return W'(pr % (2*W)'(PRIME));
   endfunction

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] v;
      for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [W-1:0] rand_op();
`ifdef MODMUL_INPUT_REDUCE_EN
      return rand_w();
`else
      return rand_w() % PRIME;
`endif
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: an accepted request completes LAT edges later with (a*b) mod prime.
   logic         m_valid = 1'b0;
   int           m_rem = 0;
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_res = '0;
   logic [W-1:0] m_pend = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid <= 1'b1;
         m_rem   <= 0;
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_res   <= '0;
      end else if (m_valid) begin
         if (m_rem == 0) begin
            m_done <= 1'b0;
            if (bus.start) begin
               m_rem  <= LAT;
               m_busy <= 1'b1;
               m_pend <= ref_mul(bus.a, bus.b);
            end
         end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_done <= 1'b1;
               m_busy <= 1'b0;
               m_res  <= m_pend;
            end
         end
      end
   end

   // Cycle-by-cycle comparison of the handshake and result against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", W'(bus.busy), W'(m_busy));
         chk("done", W'(bus.done), W'(m_done));
         chk("result", bus.result, m_res);
      end
   end

   // Issue one operation, wait (bounded) for done, check latency and result.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [W-1:0] exp, input string nm);
      int n;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = ta; bus.b = tb_v;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = rand_w(); bus.b = rand_w();
      chk({nm, "_busy_after_accept"}, W'(bus.busy), W'(1));
      n = 0;
      while (!bus.done && n < LAT + 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_latency"}, W'(n), W'(LAT));
      chk({nm, "_result"}, bus.result, exp);
      chk({nm, "_busy_at_done"}, W'(bus.busy), W'(0));
   endtask

   initial begin
      logic [W-1:0] ra, rb, x;
      int edge_n, dn, last, extra;

      bus.start = 1'b0; bus.a = '0; bus.b = '0;

      // Pin the reference function with hand-computed values.
      chk("ref_3x5", ref_mul(W'(3), W'(5)), W'(15));
      chk("ref_pm1_sq", ref_mul(PRIME - W'(1), PRIME - W'(1)), W'(1));
      chk("ref_inv2", ref_mul(W'(2), (PRIME + W'(1)) >> 1), W'(1));
      chk("ref_by1", ref_mul(W'(32'hDEADBEEF), W'(1)), W'(32'hDEADBEEF));

      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", W'(bus.busy), W'(0));
      chk("reset_done", W'(bus.done), W'(0));
      chk("reset_result", bus.result, W'(0));
      rst_n = 1'b1;

      run_op(W'(3), W'(5), W'(15), "mul_3x5");
      run_op(PRIME - W'(1), PRIME - W'(1), W'(1), "pm1_sq");
      run_op(W'(2), (PRIME + W'(1)) >> 1, W'(1), "inv2");
      run_op(W'(16'h1234), W'(0), W'(0), "b_zero");
      run_op(PRIME - W'(1), W'(1), PRIME - W'(1), "b_one");
      run_op(W'(0), PRIME - W'(2), W'(0), "a_zero");
`ifdef MODMUL_INPUT_REDUCE_EN
      run_op(PRIME + W'(3), W'(5), W'(15), "unreduced_a");
      x = '1;
      run_op(x, x, ref_mul(x, x), "all_ones");
`endif

      // start held high: three operations back to back.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = W'(7); bus.b = W'(9);
      edge_n = 0; dn = 0; last = 0;
      while (dn < 3 && edge_n < 4 * (LAT + 1)) begin
         @(posedge clk); #1;
         edge_n++;
         if (bus.done) begin
            if (dn > 0) chk("b2b_spacing", W'(edge_n - last), W'(LAT + 1));
            chk("b2b_result", bus.result, W'(63));
            last = edge_n;
            dn++;
            if (dn == 3) bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      chk("b2b_count", W'(dn), W'(3));

      // start pulse mid-operation is ignored.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = W'(11); bus.b = W'(13);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (99) begin @(posedge clk); #1; end
      bus.start = 1'b1; bus.a = W'(5); bus.b = W'(5);
      @(posedge clk); #1;
      bus.start = 1'b0;
      edge_n = 100;
      while (!bus.done && edge_n < LAT + 10) begin @(posedge clk); #1; edge_n++; end
      chk("mid_start_latency", W'(edge_n), W'(LAT));
      chk("mid_start_result", bus.result, W'(143));
      extra = 0;
      repeat (LAT + 20) begin @(posedge clk); #1; if (bus.done) extra++; end
      chk("mid_start_no_extra_done", W'(extra), W'(0));

      // Reset in the middle of an operation.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = W'(21); bus.b = W'(22);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (127) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_busy", W'(bus.busy), W'(0));
      chk("abort_done", W'(bus.done), W'(0));
      chk("abort_result", bus.result, W'(0));
      extra = 0;
      repeat (LAT + 20) begin @(posedge clk); #1; if (bus.done) extra++; end
      chk("abort_no_done", W'(extra), W'(0));
      ra = rand_op(); rb = rand_op();
      run_op(ra, rb, ref_mul(ra, rb), "after_abort");

      // Random sweep.
      for (int i = 0; i < N_RAND; i++) begin
         ra = rand_op(); rb = rand_op();
         if (i % 17 == 0) rb = W'(1);
         run_op(ra, rb, ref_mul(ra, rb), "rand");
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
